// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller for programmable serial pattern detection.
// Latches a 1..MAX_LEN bit pattern with overlap/target settings, accepts bits
// over a valid/ready handshake, counts matches and signals done at target.
// Optional feature macro: SEQ_DETECT_CTRL_TIMEOUT_EN adds an idle timeout
// (parameter TO_CYCLES, output timeout) that returns RUN to IDLE.
module seq_detect_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TO_CYCLES = 16
`endif
    ,
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_data,
    output logic               bit_ready,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               err_cfg
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] idle_q, idle_d;
    logic            timeout_d;
`endif

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    // Only MAX_LEN-1 older bits are kept; the newest bit comes from bit_data.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_d;
    logic               err_d;

    logic [MAX_LEN-1:0] ones;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic               hit;
    logic               cfg_bad;
    logic [CNT_W-1:0]   cnt_inc;

    // Next-state, config latching, shift/match evaluation and run sequencing.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        err_d   = 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        idle_d    = '0;
        timeout_d = 1'b0;
`endif

        // Config is writable only outside RUN; a same-cycle start sees it.
        if (cfg_we && (state_q != RUN)) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
            tgt_d = cfg_target;
        end
        cfg_bad = (len_d == '0) || (len_d > LEN_W'(MAX_LEN)) || (tgt_d == '0);

        ones    = '1;
        mask    = ~(ones << len_q);
        hist_n  = {hist_q, bit_data};
        fill_n  = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        hit     = (fill_n == len_q) && ((hist_n & mask) == (pat_q & mask));
        cnt_inc = cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        hist_d  = '0;
                        fill_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                if (cfg_we) begin
                    err_d = 1'b1;
                end
                if (bit_valid) begin
                    hist_d = hist_n[MAX_LEN-2:0];
                    fill_d = fill_n;
                    if (hit) begin
                        cnt_d   = cnt_inc;
                        match_d = 1'b1;
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if (cnt_inc == tgt_q) begin
                            state_d = DONE;
                        end
                    end
                end
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                else if (idle_q == TO_W'(TO_CYCLES - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over start and over any bit accepted this cycle.
        if (abort) begin
            state_d = IDLE;
            hist_d  = hist_q;
            fill_d  = fill_q;
            cnt_d   = cnt_q;
            match_d = 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            idle_d    = '0;
            timeout_d = 1'b0;
`endif
        end
    end

    // State, config, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            tgt_q       <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            match_pulse <= 1'b0;
            err_cfg     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bit_ready   <= 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            idle_q  <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            ovl_q       <= ovl_d;
            tgt_q       <= tgt_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            match_pulse <= match_d;
            err_cfg     <= err_d;
            busy        <= (state_d == RUN);
            done        <= (state_d == DONE);
            bit_ready   <= (state_d == RUN);
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            idle_q  <= idle_d;
            timeout <= timeout_d;
`endif
        end
    end

    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed, table-driven bench for seq_detect_ctrl (MAX_LEN=8, CNT_W=8).
module tb_seq_detect_ctrl;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       bit_valid;
    logic       bit_data;
    logic       bit_ready;
    logic       match_pulse;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic       err_cfg;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int errors = 0;

    seq_detect_ctrl #(
        .MAX_LEN(8),
        .CNT_W  (8)
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        ,
        .TO_CYCLES(16)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_target (cfg_target),
        .start      (start),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .bit_ready  (bit_ready),
        .match_pulse(match_pulse),
        .match_count(match_count),
        .busy       (busy),
        .done       (done),
        .err_cfg    (err_cfg)
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        ,
        .timeout    (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected output vector: {bit_ready, match_pulse, match_count, busy, done, err_cfg}
    typedef struct packed {
        logic        we;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic        ovl;
        logic [7:0]  tgt;
        logic        st;
        logic        ab;
        logic        va;
        logic        d;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [7:0] pat, input logic [3:0] len,
                                input logic ovl, input logic [7:0] tgt, input logic st,
                                input logic ab, input logic va, input logic d,
                                input logic rdy, input logic mp, input logic [7:0] cnt,
                                input logic bsy, input logic dn, input logic er);
        vec_t v;
        v.we = we; v.pat = pat; v.len = len; v.ovl = ovl; v.tgt = tgt;
        v.st = st; v.ab = ab; v.va = va; v.d = d;
        v.exp = {rdy, mp, cnt, bsy, dn, er};
        return v;
    endfunction

    function automatic logic [12:0] outs();
        return {bit_ready, match_pulse, match_count, busy, done, err_cfg};
    endfunction

    task automatic drive(input logic we, input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic [7:0] tgt, input logic st,
                         input logic ab, input logic va, input logic d);
        cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
        start = st; abort = ab; bit_valid = va; bit_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
    endtask

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (rdy,mp,cnt,busy,done,err)", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] p8;
        reset = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;

        // we pat len ovl tgt | st ab va d | rdy mp cnt busy done err
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // start, no config
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0B, 9, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // len 9 illegal
        vecs.push_back(mk(1, 8'h0B, 4, 1, 2, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0)); // overlap run
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0)); // match 1
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 1, 0)); // match 2 -> DONE
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 1, 0)); // bit ignored
        vecs.push_back(mk(1, 8'h0B, 4, 0, 2, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0)); // non-overlap run
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0)); // match 1
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0)); // no overlap match
        vecs.push_back(mk(1, 8'h06, 4, 0, 2, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1)); // cfg_we in RUN
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 1, 0)); // original pattern
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0)); // restart from DONE
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0)); // abort+start
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0)); // fresh start clears
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0)); // abort on match bit
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        do_reset();
        check("reset_state", outs(), 13'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].pat, vecs[i].len, vecs[i].ovl, vecs[i].tgt,
                  vecs[i].st, vecs[i].ab, vecs[i].va, vecs[i].d);
            check($sformatf("row%0d", i), outs(), vecs[i].exp);
        end

        // target 0 is rejected
        drive(1, 8'h0B, 4, 0, 0, 1, 0, 0, 0);
        check("target_zero", outs(), {1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1});

        // full-length pattern 10100101, single match ends the run
        drive(1, 8'hA5, 8, 0, 1, 1, 0, 0, 0);
        check("len8_start", outs(), {1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0});
        p8 = 8'hA5;
        for (int b = 7; b >= 1; b--) begin
            drive(0, 8'h00, 0, 0, 0, 0, 0, 1, p8[b]);
        end
        check("len8_before_last", outs(), {1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0});
        drive(0, 8'h00, 0, 0, 0, 0, 0, 1, p8[0]);
        check("len8_match_done", outs(), {1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0});

        // len 1, overlap: each '1' matches; then reset mid-run clears everything
        drive(1, 8'h01, 1, 1, 3, 1, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 0, 0, 0, 1, 1);
        check("len1_match", outs(), {1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0});
        reset = 1'b1;
        drive(0, 8'h00, 0, 0, 0, 0, 0, 1, 1);
        reset = 1'b0;
        check("reset_in_run", outs(), 13'd0);
        drive(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
        check("start_after_reset", outs(), {1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1});

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        drive(1, 8'h0B, 4, 1, 2, 1, 0, 0, 0);
        check1("to_start_busy", busy, 1'b1);
        for (int c = 1; c <= 15; c++) begin
            drive(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        end
        check1("to_busy_at_15", busy, 1'b1);
        check1("to_quiet_at_15", timeout, 1'b0);
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        check1("to_pulse", timeout, 1'b1);
        check1("to_idle", busy, 1'b0);
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        check1("to_pulse_end", timeout, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
